// File: rtl/loop_codec_pkg.sv
// loop_codec_pkg: shared constants and FSM state encoding for the loop encoder/decoder pair
package loop_codec_pkg;
  localparam int SUM_TERMS = 5;
  localparam int SUM_OFFSET = 10;
  localparam int MAX_N = 7;
  typedef enum logic [1:0] {IDLE, DIV, FACT, DONE} state_e;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: N-bit restoring unsigned divider, one quotient bit per cycle after a start pulse
module seq_divider #(
  parameter int N = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o
);
  localparam int CW = $clog2(N);
  logic [N-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0] cnt_q;
  logic [N:0] rem_sh;
  logic ge;
  // one restoring step: shift in the next dividend bit, subtract the divisor when it fits
  always_comb begin
    rem_sh = {rem_q, quo_q[N-1]};
    ge = rem_sh >= {1'b0, divisor_i};
    rem_d = N'(ge ? rem_sh - {1'b0, divisor_i} : rem_sh);
    quo_d = {quo_q[N-2:0], ge};
  end
  // dividend bits shift out of quo_q while quotient bits shift in behind them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        rem_q <= '0;
        quo_q <= dividend_i;
        cnt_q <= CW'(N - 1);
        busy_o <= 1'b1;
      end else if (busy_o) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - 1'b1;
        busy_o <= cnt_q != '0;
        done_o <= cnt_q == '0;
      end
    end
  end
  assign quotient_o = quo_q;
  assign remainder_o = rem_q;
endmodule

// File: rtl/loop_result_decoder.sv
// loop_result_decoder: recovers base operand and loop count from an encoded (sum, product) pair
module loop_result_decoder
  import loop_codec_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] sum_in,
  input  logic [W-1:0] prod_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] base_out,
  output logic         base_ok,
  output logic [3:0]   count_out,
  output logic         prod_ok
);
  state_e state_q, state_d;
  logic accept, div_busy, div_done, neg_q, bok_q, found_q, hit, last;
  logic [W:0] d_w, dividend, div_quo, div_rem;
  logic [W-1:0] prod_q, base_q, acc_q, acc_d;
  logic [3:0] k_q, fcnt_q;
  // offset removal is one bit wider than the input so extreme sums never wrap
  always_comb begin
    accept = in_valid && in_ready;
    d_w = {sum_in[W-1], sum_in} - (W+1)'(SUM_OFFSET);
    dividend = d_w[W] ? -d_w : d_w;
    acc_d = acc_q * W'(k_q);
    hit = !found_q && acc_d == prod_q;
    last = k_q == 4'(MAX_N);
  end
  seq_divider #(.N(W + 1)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(accept),
    .dividend_i(dividend),
    .divisor_i((W+1)'(SUM_TERMS)),
    .busy_o(div_busy),
    .done_o(div_done),
    .quotient_o(div_quo),
    .remainder_o(div_rem)
  );
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next-state: fixed-length divide, fixed-length factorial scan, then hold until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = accept ? DIV : IDLE;
      DIV: state_d = div_done ? FACT : DIV;
      FACT: state_d = last ? DONE : FACT;
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    in_ready = state_q == IDLE && !div_busy;
    out_valid = state_q == DONE;
  end
  // datapath: sign fix-up of the quotient, factorial scan, result registers loaded on entering DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      prod_q <= '0;
      base_q <= '0;
      bok_q <= 1'b0;
      acc_q <= '0;
      k_q <= '0;
      found_q <= 1'b0;
      fcnt_q <= '0;
      base_out <= '0;
      base_ok <= 1'b0;
      count_out <= '0;
      prod_ok <= 1'b0;
    end else begin
      if (accept) begin
        neg_q <= d_w[W];
        prod_q <= prod_in;
      end
      if (state_q == DIV && div_done) begin
        base_q <= div_rem == '0 ? W'(neg_q ? -div_quo : div_quo) : '0;
        bok_q <= div_rem == '0;
        acc_q <= W'(1);
        k_q <= 4'd1;
        found_q <= 1'b0;
        fcnt_q <= '0;
      end
      if (state_q == FACT) begin
        acc_q <= acc_d;
        k_q <= k_q + 4'd1;
        found_q <= found_q || hit;
        fcnt_q <= hit ? k_q : fcnt_q;
      end
      if (state_q == FACT && last) begin
        base_out <= base_q;
        base_ok <= bok_q;
        prod_ok <= found_q || hit;
        count_out <= hit ? k_q : fcnt_q;
      end
    end
  end
endmodule

// File: tb/tb_loop_result_decoder.sv
// tb_loop_result_decoder: scoreboard bench for the loop result decoder
module tb_loop_result_decoder;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] sum_in = '0, prod_in = '0;
  logic in_ready, out_valid, base_ok, prod_ok;
  logic [31:0] base_out;
  logic [3:0] count_out;
  typedef struct packed {
    logic [31:0] base;
    logic bok;
    logic [3:0] cnt;
    logic pok;
  } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;

  loop_result_decoder #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .prod_in(prod_in), .out_valid(out_valid), .out_ready(out_ready),
    .base_out(base_out), .base_ok(base_ok), .count_out(count_out), .prod_ok(prod_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic signed [31:0] s, input logic signed [31:0] p);
    exp_t e;
    longint d, acc;
    int c;
    d = longint'(s) - 10;
    e.bok = (d % 5) == 0;
    e.base = e.bok ? 32'(d / 5) : 32'd0;
    acc = 1;
    c = 0;
    for (int k = 1; k <= 7; k++) begin
      acc = acc * k;
      if (c == 0 && acc == longint'(p)) c = k;
    end
    e.cnt = 4'(c);
    e.pok = c != 0;
    return e;
  endfunction

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, "_base"}, longint'($signed(base_out)), longint'($signed(e.base)));
    chk({tag, "_base_ok"}, base_ok, e.bok);
    chk({tag, "_count"}, count_out, e.cnt);
    chk({tag, "_prod_ok"}, prod_ok, e.pok);
  endtask

  task automatic txn(input logic [31:0] s, input logic [31:0] p, input int hold);
    int lat;
    exp_t e;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    sum_in = s;
    prod_in = p;
    @(posedge clk);
    sb.push_back(model(s, p));
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, 41);
    if (out_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk_out("result", e);
      in_valid = 1'b1;
      sum_in = 32'd35;
      prod_in = 32'd24;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk_out("hold", e);
      end
    end else sb.delete();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk_out("rst", '0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(32'd35, 32'd24, 0);
    txn(-32'sd15, 32'd1, 0);
    txn(32'd12, 32'd25, 0);
    txn(32'd15, 32'd0, 0);
    txn(32'd20, -32'sd6, 0);
    txn(32'd2147483645, 32'd5040, 0);
    txn(32'h8000_0000, 32'd120, 0);
    txn(32'd60, 32'd720, 10);
    @(negedge clk);
    in_valid = 1'b1;
    sum_in = 32'd35;
    prod_in = 32'd24;
    @(posedge clk);
    sb.push_back(model(32'd35, 32'd24));
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk_out("abort", '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1;
    end
    chk("abort_no_partial", seen, 0);
    txn(32'd45, 32'd2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
